// File: rtl/mips_cpu_regwrite_arbiter.sv
// mips_cpu_regwrite_arbiter
//
// Arbitrates two register-file write-back requesters onto the single write
// port of the MIPS register file. Port A (main pipeline write-back) normally
// wins. Port B (load / multi-cycle unit) is boosted to priority for one cycle
// once it has been refused STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk_i              sole clock, rising edge
//   reset_ni           synchronous active-low reset
//   req_a_i/addr_a_i/data_a_i   port A request, destination, data
//   ack_a_o            port A grant (combinational)
//   req_b_i/addr_b_i/data_b_i   port B request, destination, data
//   ack_b_o            port B grant (combinational)
//   write_enable_o     register-file write strobe (registered)
//   write_address_o    register-file write address (registered)
//   data_in_o          register-file write data (registered)
//   boost_o            high while port B holds priority (registered)

module mips_cpu_regwrite_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,

    input  logic        req_a_i,
    input  logic [4:0]  addr_a_i,
    input  logic [31:0] data_a_i,
    output logic        ack_a_o,

    input  logic        req_b_i,
    input  logic [4:0]  addr_b_i,
    input  logic [31:0] data_b_i,
    output logic        ack_b_o,

    output logic        write_enable_o,
    output logic [4:0]  write_address_o,
    output logic [31:0] data_in_o,
    output logic        boost_o
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        StNormal,
        StBoost
    } state_e;

    state_e      state_q;
    logic [3:0]  wait_q;
    logic [3:0]  wait_d;
    logic        boost_q;
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;

    logic        grant;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Grants. Reset masks both so nothing is consumed while in reset.
    always_comb begin
        ack_a_o = 1'b0;
        ack_b_o = 1'b0;
        if (reset_ni) begin
            unique case (state_q)
                StNormal: begin
                    ack_a_o = req_a_i;
                    ack_b_o = req_b_i & ~req_a_i;
                end
                StBoost: begin
                    ack_b_o = req_b_i;
                    ack_a_o = req_a_i & ~req_b_i;
                end
            endcase
        end
    end

    // Starvation counter: counts consecutive refused port-B cycles.
    always_comb begin
        wait_d = 4'd0;
        if (req_b_i && !ack_b_o) begin
            wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
        end
    end

    // Write-port source mux; grants are mutually exclusive.
    always_comb begin
        grant    = ack_a_o | ack_b_o;
        sel_addr = ack_a_o ? addr_a_i : addr_b_i;
        sel_data = ack_a_o ? data_a_i : data_b_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StNormal;
            boost_q <= 1'b0;
            wait_q  <= 4'd0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            wait_q <= wait_d;

            unique case (state_q)
                StNormal: begin
                    if (wait_d == Limit) begin
                        state_q <= StBoost;
                        boost_q <= 1'b1;
                    end
                end
                StBoost: begin
                    // Leave after serving B, or if B withdrew its request.
                    if (ack_b_o || !req_b_i) begin
                        state_q <= StNormal;
                        boost_q <= 1'b0;
                    end
                end
            endcase

            if (grant) begin
                // Writes to r0 are acknowledged but discarded; zero the bus too.
                we_q    <= (sel_addr != 5'd0);
                waddr_q <= sel_addr;
                wdata_q <= (sel_addr != 5'd0) ? sel_data : 32'd0;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign write_enable_o  = we_q;
    assign write_address_o = waddr_q;
    assign data_in_o       = wdata_q;
    assign boost_o         = boost_q;

endmodule

// File: tb/tb_mips_cpu_regwrite_arbiter.sv
module tb_mips_cpu_regwrite_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        ack_a, ack_b;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] din;
    logic        boost;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_cpu_regwrite_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i           (clk),
        .reset_ni        (rst_n),
        .req_a_i         (req_a),
        .addr_a_i        (addr_a),
        .data_a_i        (data_a),
        .ack_a_o         (ack_a),
        .req_b_i         (req_b),
        .addr_b_i        (addr_b),
        .data_b_i        (data_b),
        .ack_b_o         (ack_b),
        .write_enable_o  (we),
        .write_address_o (wa),
        .data_in_o       (din),
        .boost_o         (boost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b1; addr_a = 5'd7; data_a = 32'h1111_1111;
        req_b = 1'b1; addr_b = 5'd8; data_b = 32'h2222_2222;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({ack_a, ack_b} !== 2'b00) begin
                bad++;
                $display("FAIL reset_acks cyc=%0d got=%b exp=00", c, {ack_a, ack_b});
            end
            tick();
            total++;
            if ({we, wa, din, boost} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got we=%b wa=%0d din=%h boost=%b exp 0/0/0/0",
                         c, we, wa, din, boost);
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_a = 1'b1; addr_a = 5'd5; data_a = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({ack_a, ack_b} !== 2'b10) begin
            bad++;
            $display("FAIL single_ack got=%b exp=10", {ack_a, ack_b});
        end
        tick();
        total++;
        if ({we, wa, din} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL single_write got we=%b wa=%0d din=%h exp 1/5/deadbeef", we, wa, din);
        end
        req_a = 1'b0;
        tick();
        total++;
        if ({we, wa, din} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL single_idle got we=%b wa=%0d din=%h exp 0/5/deadbeef", we, wa, din);
        end
    endtask

    task automatic test_starvation();
        req_a = 1'b1; addr_a = 5'd1; data_a = 32'h5555_5555;
        req_b = 1'b1; addr_b = 5'd9; data_b = 32'h0000_1234;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if ({ack_a, ack_b, boost} !== 3'b100) begin
                bad++;
                $display("FAIL starve_wait cyc=%0d got ackA/ackB/boost=%b exp=100",
                         c, {ack_a, ack_b, boost});
            end
            tick();
        end
        #1;
        total++;
        if ({ack_a, ack_b, boost} !== 3'b011) begin
            bad++;
            $display("FAIL starve_boost got ackA/ackB/boost=%b exp=011", {ack_a, ack_b, boost});
        end
        tick();
        req_b = 1'b0;
        total++;
        if ({we, wa, din, boost} !== {1'b1, 5'd9, 32'h1234, 1'b0}) begin
            bad++;
            $display("FAIL starve_write got we=%b wa=%0d din=%h boost=%b exp 1/9/1234/0",
                     we, wa, din, boost);
        end
        req_a = 1'b0;
        tick();
    endtask

    task automatic test_reg_zero();
        req_b = 1'b1; addr_b = 5'd0; data_b = 32'hFFFF_FFFF;
        #1;
        total++;
        if ({ack_a, ack_b} !== 2'b01) begin
            bad++;
            $display("FAIL zero_ack got=%b exp=01", {ack_a, ack_b});
        end
        tick();
        req_b = 1'b0;
        total++;
        if ({we, wa, din} !== {1'b0, 5'd0, 32'd0}) begin
            bad++;
            $display("FAIL zero_write got we=%b wa=%0d din=%h exp 0/0/0", we, wa, din);
        end
        tick();
    endtask

    task automatic test_collision();
        req_a = 1'b1; addr_a = 5'd3; data_a = 32'hA;
        req_b = 1'b1; addr_b = 5'd3; data_b = 32'hB;
        #1;
        total++;
        if ({ack_a, ack_b} !== 2'b10) begin
            bad++;
            $display("FAIL collide_ack1 got=%b exp=10", {ack_a, ack_b});
        end
        tick();
        req_a = 1'b0;
        total++;
        if ({we, wa, din} !== {1'b1, 5'd3, 32'hA}) begin
            bad++;
            $display("FAIL collide_write1 got we=%b wa=%0d din=%h exp 1/3/a", we, wa, din);
        end
        #1;
        total++;
        if ({ack_a, ack_b} !== 2'b01) begin
            bad++;
            $display("FAIL collide_ack2 got=%b exp=01", {ack_a, ack_b});
        end
        tick();
        req_b = 1'b0;
        total++;
        if ({we, wa, din} !== {1'b1, 5'd3, 32'hB}) begin
            bad++;
            $display("FAIL collide_write2 got we=%b wa=%0d din=%h exp 1/3/b", we, wa, din);
        end
        tick();
    endtask

    task automatic test_reset_in_boost();
        req_a = 1'b1; addr_a = 5'd2; data_a = 32'h22;
        req_b = 1'b1; addr_b = 5'd4; data_b = 32'h44;
        for (int c = 0; c < 4; c++) tick();
        total++;
        if (boost !== 1'b1) begin
            bad++;
            $display("FAIL rib_boost_before got=%b exp=1", boost);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ack_a, ack_b} !== 2'b00) begin
            bad++;
            $display("FAIL rib_acks_in_reset got=%b exp=00", {ack_a, ack_b});
        end
        tick();
        rst_n = 1'b1;
        total++;
        if ({boost, we} !== 2'b00) begin
            bad++;
            $display("FAIL rib_after_reset got boost/we=%b exp=00", {boost, we});
        end
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if ({ack_b, boost} !== 2'b00) begin
                bad++;
                $display("FAIL rib_recount cyc=%0d got ackB/boost=%b exp=00", c, {ack_b, boost});
            end
            tick();
        end
        total++;
        if (boost !== 1'b1) begin
            bad++;
            $display("FAIL rib_reboost got=%b exp=1", boost);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
    endtask

    // Random traffic against a rule-level model: B has priority only while
    // boosted; boosting follows LIMIT consecutive refusals of a pending B.
    task automatic test_random();
        bit          pa, pb, ga, gb, was_boost;
        int          m_wait;
        bit          m_boost, m_we;
        logic [4:0]  m_addr;
        logic [31:0] m_data;

        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        tick();
        rst_n = 1'b1;
        pa = 0; pb = 0;
        m_wait = 0; m_boost = 0; m_we = 0; m_addr = 0; m_data = 0;

        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            if (pb && $urandom_range(0, 15) == 0) pb = 0;
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1;
                addr_a = 5'($urandom_range(0, 7));
                data_a = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1;
                addr_b = 5'($urandom_range(0, 7));
                data_b = $urandom;
            end
            req_a = pa;
            req_b = pb;
            #1;
            ga = rst_n && pa && !(m_boost && pb);
            gb = rst_n && pb && !ga;
            total++;
            if ({ack_a, ack_b} !== {ga, gb}) begin
                bad++;
                $display("FAIL rand_acks cyc=%0d got=%b exp=%b", c, {ack_a, ack_b}, {ga, gb});
            end
            tick();

            if (!rst_n) begin
                m_boost = 0; m_wait = 0; m_we = 0; m_addr = 0; m_data = 0;
            end else begin
                if (ga || gb) begin
                    m_addr = ga ? addr_a : addr_b;
                    m_data = ga ? data_a : data_b;
                    m_we   = (m_addr != 0);
                    if (m_addr == 0) m_data = 0;
                end else begin
                    m_we = 0;
                end
                was_boost = m_boost;
                if (pb && !gb) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
                else m_wait = 0;
                if (was_boost) begin
                    if (gb || !pb) m_boost = 0;
                end else if (m_wait == int'(LIMIT)) begin
                    m_boost = 1;
                end
            end
            if (ga) pa = 0;
            if (gb) pb = 0;

            total++;
            if ({we, wa, din, boost} !== {m_we, m_addr, m_data, m_boost}) begin
                bad++;
                $display("FAIL rand_regs cyc=%0d got we=%b wa=%0d din=%h boost=%b exp %b/%0d/%h/%b",
                         c, we, wa, din, boost, m_we, m_addr, m_data, m_boost);
            end
        end
        rst_n = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        req_a  = 1'b0; addr_a = 5'd0; data_a = 32'd0;
        req_b  = 1'b0; addr_b = 5'd0; data_b = 32'd0;
        test_reset();
        test_single();
        test_starvation();
        test_reg_zero();
        test_collision();
        test_reset_in_boost();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_regwrite_arbiter.md
MIPS_CPU_REGWRITE_ARBITER -- requirements
Module: mips_cpu_regwrite_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles a pending port-B request may be refused before port B is boosted to priority; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-low; asserted when 0 and sampled only on posedge clk.
REQ-004 reqA  input  1  port A (main pipeline write-back) write request.
REQ-005 addrA  input  5  port A destination register.
REQ-006 dataA  input  32  port A write data.
REQ-007 ackA  output  1  port A grant; combinational, valid in the cycle the request is accepted.
REQ-008 reqB  input  1  port B (load/multi-cycle unit) write request.
REQ-009 addrB  input  5  port B destination register.
REQ-010 dataB  input  32  port B write data.
REQ-011 ackB  output  1  port B grant; combinational.
REQ-012 writeEnable  output  1  register-file write strobe; registered.
REQ-013 writeAddress  output  5  register-file write address; registered.
REQ-014 dataIn  output  32  register-file write data; registered.
REQ-015 boost  output  1  high while the FSM is in BOOST; registered.

Function
REQ-016 Handshake: a requester holds req, addr and data stable until it samples ack=1 on a posedge; the request is consumed on that edge.
REQ-017 At most one of ackA/ackB is 1 per cycle.
REQ-018 ack is never 1 unless the matching req is 1.
REQ-019 FSM has two states, NORMAL and BOOST.
REQ-020 NORMAL: ackA = reqA; ackB = reqB & ~reqA.
REQ-021 BOOST: ackB = reqB; ackA = reqA & ~reqB.
REQ-022 Wait counter (4 bits, saturating at 15) increments each cycle with reqB=1 and ackB=0, clears to 0 on any cycle with ackB=1 or reqB=0.
REQ-023 NORMAL->BOOST on the edge where the counter value after update equals STARVE_LIMIT.
REQ-024 BOOST->NORMAL on the edge following the first cycle in BOOST with ackB=1.
REQ-025 BOOST->NORMAL also occurs if reqB drops while in BOOST (request withdrawn), and the counter clears.
REQ-026 Write-port latency is one cycle: on the edge after a cycle with ackX=1, writeAddress=addrX and dataIn=dataX, with writeEnable=1 iff addrX != 0.
REQ-027 A grant to register 0 is still acknowledged but produces writeEnable=0, writeAddress=0 and dataIn=0.
REQ-028 With no ack in a cycle, the next edge drives writeEnable=0; writeAddress and dataIn hold their previous values.
REQ-029 Simultaneous reqA and reqB to the same address: only the granted port is written that cycle; the other port is written in a later cycle, so the register ends up holding the later write.

Reset
REQ-030 On a posedge with reset=0: writeEnable=0, writeAddress=0, dataIn=0, boost=0, FSM=NORMAL, counter=0.
REQ-031 While reset=0, ackA=0 and ackB=0 regardless of requests.
REQ-032 Reset mid-operation (any state, any counter value) takes effect on that edge.
REQ-033 Requests pending at reset release are treated as new requests with counter 0.

Verification
REQ-034 Reset held 2 cycles with reqA=reqB=1 -> ackA=ackB=0 throughout; after the first reset edge writeEnable=0, writeAddress=0, dataIn=0, boost=0.
REQ-035 Single request: reqA=1, addrA=5, dataA=0xDEADBEEF -> ackA=1 that cycle; next cycle writeEnable=1, writeAddress=5, dataIn=0xDEADBEEF; following idle cycle writeEnable=0 with address and data held.
REQ-036 Starvation, STARVE_LIMIT=4: reqA=1 every cycle and reqB=1, addrB=9, dataB=0x1234 from cycle 0 -> ackB=0 for cycles 0-3; boost=1 from cycle 4; ackB=1 and ackA=0 in cycle 4; write of reg 9 = 0x1234 appears in cycle 5; boost=0 from cycle 5.
REQ-037 Register zero: reqB alone with addrB=0, dataB=0xFFFFFFFF -> ackB=1; next cycle writeEnable=0, writeAddress=0, dataIn=0.
REQ-038 Same-address collision: reqA with addr 3, data 0xA and reqB with addr 3, data 0xB, both in NORMAL -> reg 3 written 0xA first, then 0xB next cycle; final value 0xB.
REQ-039 Reset while boost=1 and counter=4 -> next cycle boost=0 and counter=0; a held reqB needs 4 more refused cycles to boost again.
